// File: rtl/softusb_dmem_arbiter.sv
// Arbitrates the single-port softusb data memory between the navre CPU and a DMA requester.
// The CPU has priority; a starvation counter forces a one-cycle DMA grant after max_wait denials.
module softusb_dmem_arbiter #(
  parameter int unsigned dmem_width = 13,
  parameter int unsigned max_wait   = 8,
  parameter int unsigned wait_width = 4
) (
  input  logic                  usb_clk,
  input  logic                  usb_rst,

  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [dmem_width-1:0] cpu_a,
  input  logic [7:0]            cpu_dw,
  output logic [7:0]            cpu_dr,
  output logic                  cpu_stall,

  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [dmem_width-1:0] dma_a,
  input  logic [7:0]            dma_dw,
  output logic                  dma_ack,
  output logic [7:0]            dma_dr,
  output logic                  dma_drv,

  output logic                  mem_we,
  output logic [dmem_width-1:0] mem_a,
  output logic [7:0]            mem_dw,
  input  logic [7:0]            mem_dr
);

  localparam logic [wait_width-1:0] MaxWait = wait_width'(max_wait);

  logic                  cpu_act;
  logic                  force_grant;
  logic                  dma_own;
  logic                  cpu_own;
  logic [wait_width-1:0] wait_cnt_q;
  logic [wait_width-1:0] wait_cnt_d;
  logic                  rd_pend_q;
  logic                  rd_pend_d;
  logic [7:0]            dr_q;
  logic [7:0]            dr_d;

  assign cpu_act     = cpu_re | cpu_we;
  assign force_grant = dma_req & (wait_cnt_q == MaxWait);

  // Ownership is suppressed while in reset so no access or handshake escapes.
  assign dma_own = ~usb_rst & (force_grant | (~cpu_act & dma_req));
  assign cpu_own = ~usb_rst & ~force_grant & cpu_act;

  assign cpu_stall = ~usb_rst & force_grant & cpu_act;
  assign dma_ack   = dma_own;

  assign mem_a  = dma_own ? dma_a  : cpu_a;
  assign mem_dw = dma_own ? dma_dw : cpu_dw;
  assign mem_we = dma_own ? dma_we : (cpu_own & cpu_we);

  assign cpu_dr = mem_dr;

  // Read data is presented straight from memory on the pulse cycle, then held.
  assign dma_drv = rd_pend_q;
  assign dma_dr  = rd_pend_q ? mem_dr : dr_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    rd_pend_d  = dma_own & ~dma_we;
    dr_d       = dr_q;
    if (dma_own) begin
      wait_cnt_d = '0;
    end else if (dma_req && cpu_own && (wait_cnt_q != MaxWait)) begin
      wait_cnt_d = wait_cnt_q + wait_width'(1);
    end
    if (rd_pend_q) begin
      dr_d = mem_dr;
    end
  end

  always_ff @(posedge usb_clk or posedge usb_rst) begin
    if (usb_rst) begin
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      dr_q       <= 8'h00;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      dr_q       <= dr_d;
    end
  end

endmodule
